isa_vram_bridge: RTL

Transfer stage directly downstream of the ISA slave bus controller. It accepts decoded host memory cycles in the A0000h–BFFFFh window and turns them into word accesses on the VRAM arbiter port. Writes are posted through a 4-entry FIFO. Reads drain the FIFO, then stall the host through `isa_wait` until VRAM returns data. The display fetcher owns VRAM priority in the arbiter, so this block must tolerate arbitrary grant delay.

---
 rtl/isa_vram_bridge.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/isa_vram_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : isa_vram_bridge
//  Description : Turns decoded ISA host memory cycles in the VGA window into
//                word accesses on the VRAM arbiter port. Writes are posted
//                through a small FIFO; reads drain the FIFO first and stall
//                the host via isa_wait until VRAM returns data.
//  Revision    : 1.0 - initial release
// ============================================================================
module isa_vram_bridge #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [19:0] WIN_BASE   = 20'hA0000,
    parameter logic [19:0] WIN_TOP    = 20'hBFFFF
) (
    input  logic        FPGACLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [19:0] req_addr,
    input  logic        req_sbhe,
    input  logic        req_wr,
    input  logic [15:0] req_wdata,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        isa_wait,
    output logic        vram_req,
    input  logic        vram_gnt_ack,
    output logic        vram_we,
    output logic [1:0]  vram_be,
    output logic [15:0] vram_addr,
    output logic [15:0] vram_wdata,
    input  logic [15:0] vram_rdata,
    output logic [7:0]  drop_count
);

    localparam int unsigned          c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned          c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]   c_FULL  = c_CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_ISSUE = 2'd1,
        RD_ISSUE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    // Posted-write FIFO storage and bookkeeping
    logic [15:0]          r_fifo_addr [FIFO_DEPTH];
    logic [1:0]           r_fifo_be   [FIFO_DEPTH];
    logic [15:0]          r_fifo_data [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_CNT_W-1:0]   w_count_next;

    // Single read-holding register
    logic                 r_rd_pend;
    logic                 w_rd_pend_next;
    logic [15:0]          r_rd_addr;
    logic [1:0]           r_rd_be;

    logic                 r_rd_valid;
    logic [15:0]          r_rd_data;
    logic                 r_isa_wait;
    logic                 w_isa_wait_next;
    logic [7:0]           r_drop_count;

    logic                 w_accept;
    logic                 w_in_win;
    logic [15:0]          w_word_addr;
    logic [1:0]           w_be;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_rd_accept;
    logic                 w_oow_rd;
    logic                 w_drop;
    logic                 w_rd_done;
    logic                 w_full;

    // Request decode: window check, word address and lane selection
    assign w_in_win    = (req_addr >= WIN_BASE) && (req_addr <= WIN_TOP);
    assign w_word_addr = req_addr[16:1];
    // An odd address always lands on the high lane, whatever SBHE says
    assign w_be        = req_addr[0] ? 2'b10 : (req_sbhe ? 2'b01 : 2'b11);

    assign w_full      = (r_count == c_FULL);
    // Gated by RESET so the controller never sees ready while reset is held
    assign req_ready   = RESET && !w_full && !r_rd_pend && (r_state != RD_ISSUE);
    assign w_accept    = req_valid && req_ready;
    assign w_push      = w_accept && req_wr && w_in_win;
    assign w_rd_accept = w_accept && !req_wr && w_in_win;
    assign w_oow_rd    = w_accept && !req_wr && !w_in_win;
    assign w_drop      = w_accept && !w_in_win;
    assign w_pop       = (r_state == WR_ISSUE) && vram_gnt_ack;
    assign w_rd_done   = (r_state == RD_ISSUE) && vram_gnt_ack;

    assign w_count_next    = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    assign w_rd_pend_next  = w_rd_accept ? 1'b1 : (w_rd_done ? 1'b0 : r_rd_pend);
    assign w_isa_wait_next = w_rd_pend_next || (w_state_next == RD_ISSUE) || (w_count_next == c_FULL);

    // FIFO entry storage; contents are only observed through valid pointers
    always_ff @(posedge FPGACLK) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= w_word_addr;
            r_fifo_be[r_wr_ptr]   <= w_be;
            r_fifo_data[r_wr_ptr] <= req_wdata;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge FPGACLK or negedge RESET) begin
        if (!RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
        end
    end

    // Read holding, read return, host stall and drop counter
    always_ff @(posedge FPGACLK or negedge RESET) begin
        if (!RESET) begin
            r_rd_pend    <= 1'b0;
            r_rd_addr    <= '0;
            r_rd_be      <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
            r_isa_wait   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_rd_pend  <= w_rd_pend_next;
            r_isa_wait <= w_isa_wait_next;
            r_rd_valid <= 1'b0;
            if (w_rd_accept) begin
                r_rd_addr <= w_word_addr;
                r_rd_be   <= w_be;
            end
            if (w_rd_done) begin
                r_rd_data  <= vram_rdata;
                r_rd_valid <= 1'b1;
            end else if (w_oow_rd) begin
                // Unmapped reads float high, like an empty ISA bus
                r_rd_data  <= 16'hFFFF;
                r_rd_valid <= 1'b1;
            end
            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge FPGACLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and arbiter-side outputs; writes always drain before a read
    always_comb begin
        w_state_next = r_state;
        vram_req     = 1'b0;
        vram_we      = 1'b0;
        vram_be      = '0;
        vram_addr    = '0;
        vram_wdata   = '0;
        case (r_state)
            IDLE: begin
                if (r_count != '0) begin
                    w_state_next = WR_ISSUE;
                end else if (r_rd_pend) begin
                    w_state_next = RD_ISSUE;
                end
            end
            WR_ISSUE: begin
                vram_req   = 1'b1;
                vram_we    = 1'b1;
                vram_be    = r_fifo_be[r_rd_ptr];
                vram_addr  = r_fifo_addr[r_rd_ptr];
                vram_wdata = r_fifo_data[r_rd_ptr];
                if (vram_gnt_ack) begin
                    // Stay put when another entry is ready so writes stream back to back
                    w_state_next = (w_count_next != '0) ? WR_ISSUE : IDLE;
                end
            end
            RD_ISSUE: begin
                vram_req  = 1'b1;
                vram_be   = r_rd_be;
                vram_addr = r_rd_addr;
                if (vram_gnt_ack) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign rd_valid   = r_rd_valid;
    assign rd_data    = r_rd_data;
    assign isa_wait   = r_isa_wait;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire
